// File: rtl/egress_interface_pkg.sv
// Shared definitions for the egress interface: command/response field
// positions, status codes, FSM state encoding and the NIF write opcode.
package egress_interface_pkg;

    localparam int PACKET_W = 128;
    localparam int ADDR_W   = 64;
    localparam int LEN_W    = 36;
    localparam int TAG_W    = 8;
    localparam int ERR_W    = 7;
    localparam int TYPE_W   = 4;
    // ceil((2^36-1)/16) needs 33 bits
    localparam int BEATS_W  = 33;

    // Command and response share the address/length/tag layout.
    localparam int CMD_ADDR_LSB   = 64;
    localparam int CMD_LEN_LSB    = 28;
    localparam int CMD_TAG_LSB    = 20;
    localparam int RSP_ERR_LSB    = 2;
    localparam int RSP_STATUS_LSB = 0;

    localparam logic [1:0] EGRESS_STATUS_OK         = 2'b00;
    localparam logic [1:0] EGRESS_STATUS_ZERO_LEN   = 2'b01;
    localparam logic [1:0] EGRESS_STATUS_MASTER_ERR = 2'b10;

    // NIF master write-request opcode (mirrors soc_it_defs)
    localparam logic [TYPE_W-1:0] NIF_MASTER_CMD_WRREQ = 4'h2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQUEST   = 3'd1,
        ST_STREAM    = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESPOND   = 3'd4
    } egress_state_t;

    // Assemble a completion response; unused bits are zero.
    function automatic logic [PACKET_W-1:0] pack_response(
        input logic [ADDR_W-1:0] addr,
        input logic [LEN_W-1:0]  len,
        input logic [TAG_W-1:0]  tag,
        input logic [ERR_W-1:0]  err,
        input logic [1:0]        status
    );
        logic [PACKET_W-1:0] rsp;
        rsp = '0;
        rsp[CMD_ADDR_LSB +: ADDR_W]  = addr;
        rsp[CMD_LEN_LSB +: LEN_W]    = len;
        rsp[CMD_TAG_LSB +: TAG_W]    = tag;
        rsp[RSP_ERR_LSB +: ERR_W]    = err;
        rsp[RSP_STATUS_LSB +: 2]     = status;
        return rsp;
    endfunction

endpackage

// File: rtl/egress_interface_cmd_decode.sv
// Combinational decode of a write command packet: field extraction and
// rounding of the byte length up to a whole number of data beats.
module egress_interface_cmd_decode
    import egress_interface_pkg::*;
#(
    parameter int C_PACKET_WIDTH = 128,
    parameter int C_BEAT_BYTES   = 16
)
(
    input  logic [C_PACKET_WIDTH-1:0] cmd,
    output logic [ADDR_W-1:0]         addr,
    output logic [LEN_W-1:0]          len,
    output logic [TAG_W-1:0]          tag,
    output logic [BEATS_W-1:0]        beats,
    output logic                      zero_len
);

    localparam int BEAT_SHIFT = $clog2(C_BEAT_BYTES);

    // One extra bit so a length of 2^36-1 plus the rounding term cannot wrap.
    logic [LEN_W:0] len_round;
    logic           unused_reserved;

    assign addr      = cmd[CMD_ADDR_LSB +: ADDR_W];
    assign len       = cmd[CMD_LEN_LSB +: LEN_W];
    assign tag       = cmd[CMD_TAG_LSB +: TAG_W];
    assign len_round = {1'b0, len} + (LEN_W+1)'(C_BEAT_BYTES - 1);
    assign beats     = BEATS_W'(len_round >> BEAT_SHIFT);
    assign zero_len  = (len == '0);

    // Reserved low bits carry no meaning for this block.
    assign unused_reserved = ^cmd[CMD_TAG_LSB-1:0];

endmodule

// File: rtl/egress_interface.sv
// Egress interface: takes a write command from the layer engine, issues one
// NIF master write request, streams the payload beats straight through to
// the master data port and returns a completion response.
// Optional statistics counters are enabled with EGRESS_INTERFACE_PERF_CNT_EN.
module egress_interface
    import egress_interface_pkg::*;
#(
    parameter int C_PACKET_WIDTH = 128,
    parameter int C_BEAT_BYTES   = 16
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ext_input_valid,
    output logic                      ext_input_accept,
    input  logic [C_PACKET_WIDTH-1:0] ext_input_payload,
    output logic                      ext_output_valid,
    input  logic                      ext_output_accept,
    output logic [C_PACKET_WIDTH-1:0] ext_output_payload,
    output logic                      master_request,
    input  logic                      master_request_ack,
    input  logic                      master_request_complete,
    input  logic [ERR_W-1:0]          master_request_error,
    output logic [TYPE_W-1:0]         master_request_type,
    output logic [ADDR_W-1:0]         master_request_local_address,
    output logic [LEN_W-1:0]          master_request_length,
    output logic                      master_dataout_src_rdy,
    input  logic                      master_dataout_dst_rdy,
    output logic [C_PACKET_WIDTH-1:0] master_dataout
`ifdef EGRESS_INTERFACE_PERF_CNT_EN
    ,
    output logic [31:0]               stat_beat_count,
    output logic [31:0]               stat_stall_count
`endif
);

    egress_state_t state_reg, state_next;

    logic [ADDR_W-1:0]  addr_reg;
    logic [LEN_W-1:0]   len_reg;
    logic [TAG_W-1:0]   tag_reg;
    logic [BEATS_W-1:0] beats_left_reg;
    logic               zero_len_reg;
    logic               complete_flag_reg;
    logic [ERR_W-1:0]   err_reg;

    logic [ADDR_W-1:0]  dec_addr;
    logic [LEN_W-1:0]   dec_len;
    logic [TAG_W-1:0]   dec_tag;
    logic [BEATS_W-1:0] dec_beats;
    logic               dec_zero_len;

    logic               cmd_take;
    logic               beat_xfer;
    logic               last_beat;
    logic               complete_seen;
    logic               complete_track;
    logic [1:0]         resp_status;
    logic [PACKET_W-1:0] resp_word;

    egress_interface_cmd_decode #(
        .C_PACKET_WIDTH (C_PACKET_WIDTH),
        .C_BEAT_BYTES   (C_BEAT_BYTES)
    ) u_cmd_decode (
        .cmd      (ext_input_payload),
        .addr     (dec_addr),
        .len      (dec_len),
        .tag      (dec_tag),
        .beats    (dec_beats),
        .zero_len (dec_zero_len)
    );

    assign cmd_take       = (state_reg == ST_IDLE) && ext_input_valid;
    assign beat_xfer      = (state_reg == ST_STREAM) && ext_input_valid && master_dataout_dst_rdy;
    assign last_beat      = beat_xfer && (beats_left_reg == BEATS_W'(1));
    // A complete pulse in the same cycle as the last beat counts immediately.
    assign complete_seen  = complete_flag_reg || master_request_complete;
    // RESPOND is excluded so the response stays stable while it is offered.
    assign complete_track = (state_reg == ST_REQUEST) || (state_reg == ST_STREAM) ||
                            (state_reg == ST_WAIT_DONE);

    assign resp_status = zero_len_reg       ? EGRESS_STATUS_ZERO_LEN :
                         (err_reg != '0)    ? EGRESS_STATUS_MASTER_ERR :
                                              EGRESS_STATUS_OK;
    assign resp_word   = pack_response(addr_reg, len_reg, tag_reg, err_reg, resp_status);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (ext_input_valid) begin
                    state_next = dec_zero_len ? ST_RESPOND : ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (master_request_ack) begin
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (last_beat) begin
                    state_next = complete_seen ? ST_RESPOND : ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (complete_seen) begin
                    state_next = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (ext_output_accept) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output decode; the streaming path is a zero-latency pass-through
    always_comb begin
        ext_input_accept             = 1'b0;
        ext_output_valid             = 1'b0;
        ext_output_payload           = '0;
        master_request               = 1'b0;
        master_request_type          = '0;
        master_request_local_address = '0;
        master_request_length        = '0;
        master_dataout_src_rdy       = 1'b0;
        master_dataout               = '0;
        case (state_reg)
            ST_IDLE: begin
                ext_input_accept = 1'b1;
            end
            ST_REQUEST: begin
                master_request               = 1'b1;
                master_request_type          = NIF_MASTER_CMD_WRREQ;
                master_request_local_address = addr_reg;
                master_request_length        = len_reg;
            end
            ST_STREAM: begin
                ext_input_accept       = master_dataout_dst_rdy;
                master_dataout_src_rdy = ext_input_valid;
                master_dataout         = ext_input_payload;
            end
            ST_RESPOND: begin
                ext_output_valid   = 1'b1;
                ext_output_payload = resp_word;
            end
            default: begin
            end
        endcase
    end

    // Latch the command fields and track the remaining beat count
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg       <= '0;
            len_reg        <= '0;
            tag_reg        <= '0;
            beats_left_reg <= '0;
            zero_len_reg   <= 1'b0;
        end else if (cmd_take) begin
            addr_reg       <= dec_addr;
            len_reg        <= dec_len;
            tag_reg        <= dec_tag;
            beats_left_reg <= dec_beats;
            zero_len_reg   <= dec_zero_len;
        end else if (beat_xfer) begin
            beats_left_reg <= beats_left_reg - BEATS_W'(1);
        end else if ((state_reg == ST_RESPOND) && ext_output_accept) begin
            zero_len_reg   <= 1'b0;
        end
    end

    // Sticky completion flag and error code, held until the response is taken
    always_ff @(posedge clk) begin
        if (rst) begin
            complete_flag_reg <= 1'b0;
            err_reg           <= '0;
        end else if (cmd_take || ((state_reg == ST_RESPOND) && ext_output_accept)) begin
            complete_flag_reg <= 1'b0;
            err_reg           <= '0;
        end else if (complete_track && master_request_complete && !complete_flag_reg) begin
            complete_flag_reg <= 1'b1;
            err_reg           <= master_request_error;
        end
    end

`ifdef EGRESS_INTERFACE_PERF_CNT_EN
    // Free-running beat and stall counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_beat_count  <= '0;
            stat_stall_count <= '0;
        end else begin
            if (beat_xfer) begin
                stat_beat_count <= stat_beat_count + 32'd1;
            end
            if ((state_reg == ST_STREAM) && ext_input_valid && !master_dataout_dst_rdy) begin
                stat_stall_count <= stat_stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_egress_interface.sv
// Scoreboard bench for egress_interface: expected requests, beats and
// responses are queued as stimulus is driven and checked as the DUT emits them.
module tb_egress_interface;
    import egress_interface_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         ext_input_valid;
    logic         ext_input_accept;
    logic [127:0] ext_input_payload;
    logic         ext_output_valid;
    logic         ext_output_accept;
    logic [127:0] ext_output_payload;
    logic         master_request;
    logic         master_request_ack;
    logic         master_request_complete;
    logic [6:0]   master_request_error;
    logic [3:0]   master_request_type;
    logic [63:0]  master_request_local_address;
    logic [35:0]  master_request_length;
    logic         master_dataout_src_rdy;
    logic         master_dataout_dst_rdy;
    logic [127:0] master_dataout;
`ifdef EGRESS_INTERFACE_PERF_CNT_EN
    logic [31:0]  stat_beat_count;
    logic [31:0]  stat_stall_count;
`endif

    egress_interface dut (
        .clk                          (clk),
        .rst                          (rst),
        .ext_input_valid              (ext_input_valid),
        .ext_input_accept             (ext_input_accept),
        .ext_input_payload            (ext_input_payload),
        .ext_output_valid             (ext_output_valid),
        .ext_output_accept            (ext_output_accept),
        .ext_output_payload           (ext_output_payload),
        .master_request               (master_request),
        .master_request_ack           (master_request_ack),
        .master_request_complete      (master_request_complete),
        .master_request_error         (master_request_error),
        .master_request_type          (master_request_type),
        .master_request_local_address (master_request_local_address),
        .master_request_length        (master_request_length),
        .master_dataout_src_rdy       (master_dataout_src_rdy),
        .master_dataout_dst_rdy       (master_dataout_dst_rdy),
        .master_dataout               (master_dataout)
`ifdef EGRESS_INTERFACE_PERF_CNT_EN
        ,
        .stat_beat_count              (stat_beat_count),
        .stat_stall_count             (stat_stall_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [35:0] len;
    } req_t;

    logic [127:0] exp_beat_q[$];
    logic [127:0] exp_resp_q[$];
    req_t         exp_req_q[$];

    int n_cmp = 0;
    int n_err = 0;

    // bench-side model state
    int  stream_left = 0;
    bit  in_stream   = 0;
    int  beats_exp   = 0;
    int  stall_exp   = 0;
    bit  hold_pend   = 0;
    logic [127:0] held_payload;

    // knobs for the responder processes
    int       ack_delay  = 3;
    int       comp_target = 0;
    int       comp_delay = 0;
    logic [6:0] comp_err = '0;
    int       comp_cnt   = 0;
    bit       comp_armed = 0;
    bit       rdy_random = 0;
    bit       acc_random = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] exp_resp(input logic [63:0] a, input logic [35:0] l,
                                              input logic [7:0] t, input logic [6:0] e,
                                              input logic [1:0] s);
        return {a, l, t, 11'd0, e, s};
    endfunction

    // Master ready and response-accept drivers
    initial begin
        master_dataout_dst_rdy = 1'b1;
        ext_output_accept      = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            master_dataout_dst_rdy = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
            ext_output_accept      = acc_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Request acknowledger
    initial begin
        master_request_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (master_request && !master_request_ack && !rst) begin
                repeat (ack_delay) @(posedge clk);
                #1 master_request_ack = 1'b1;
                @(posedge clk);
                #1 master_request_ack = 1'b0;
            end
        end
    end

    // Completion generator: pulses complete after comp_target beats plus comp_delay cycles
    initial begin
        master_request_complete = 1'b0;
        master_request_error    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                comp_cnt   = 0;
                comp_armed = 0;
            end else begin
                if (master_request && master_request_ack) begin
                    comp_cnt   = 0;
                    comp_armed = 1;
                end
                if (master_dataout_src_rdy && master_dataout_dst_rdy) comp_cnt++;
                if (comp_armed && comp_cnt == comp_target) begin
                    comp_armed = 0;
                    repeat (comp_delay) @(posedge clk);
                    @(posedge clk);
                    #1;
                    master_request_complete = 1'b1;
                    master_request_error    = comp_err;
                    @(posedge clk);
                    #1;
                    master_request_complete = 1'b0;
                    master_request_error    = '0;
                end
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            stream_left = 0;
            in_stream   = 0;
            beats_exp   = 0;
            stall_exp   = 0;
            hold_pend   = 0;
        end else begin
            if (in_stream && ext_input_valid && !master_dataout_dst_rdy) stall_exp++;
            if (master_request && master_request_ack) begin
                if (exp_req_q.size() == 0) begin
                    check_eq("req_unexpected", 1, 0);
                end else begin
                    req_t r;
                    r = exp_req_q.pop_front();
                    check_eq("req_type", master_request_type, NIF_MASTER_CMD_WRREQ);
                    check_eq("req_addr", master_request_local_address, r.addr);
                    check_eq("req_len", master_request_length, r.len);
                    $display("req  addr=%h len=%0d", r.addr, r.len);
                end
                in_stream = (stream_left > 0);
            end
            if (master_dataout_src_rdy && master_dataout_dst_rdy) begin
                if (exp_beat_q.size() == 0) begin
                    check_eq("beat_unexpected", 1, 0);
                end else begin
                    check_eq("beat_data", master_dataout, exp_beat_q.pop_front());
                end
                beats_exp++;
                if (stream_left > 0) stream_left--;
                if (stream_left == 0) in_stream = 0;
            end
            if (hold_pend) check_eq("resp_stable", ext_output_payload, held_payload);
            hold_pend = 0;
            if (ext_output_valid) begin
                if (ext_output_accept) begin
                    if (exp_resp_q.size() == 0) begin
                        check_eq("resp_unexpected", 1, 0);
                    end else begin
                        check_eq("resp_payload", ext_output_payload, exp_resp_q.pop_front());
                        check_eq("resp_after_beats", stream_left, 0);
                        $display("resp tag=%h status=%b err=%h", ext_output_payload[27:20],
                                 ext_output_payload[1:0], ext_output_payload[8:2]);
                    end
                end else begin
                    hold_pend    = 1;
                    held_payload = ext_output_payload;
                end
            end
        end
    end

    task automatic send_cmd(input logic [63:0] a, input logic [35:0] l,
                            input logic [7:0] t, input logic [6:0] e);
        int nb;
        int k;
        logic [1:0] s;
        nb = int'((37'(l) + 37'd15) >> 4);
        s  = (l == 0) ? 2'b01 : ((e != 0) ? 2'b10 : 2'b00);
        exp_resp_q.push_back(exp_resp(a, l, t, (l == 0) ? 7'd0 : e, s));
        if (l != 0) exp_req_q.push_back('{a, l});
        stream_left       = nb;
        ext_input_payload = {a, l, t, 20'hABCDE};
        ext_input_valid   = 1'b1;
        k = 0;
        while (1) begin
            @(negedge clk);
            if (ext_input_accept) break;
            if (++k > 200) begin
                check_eq("cmd_accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        ext_input_valid   = 1'b0;
        ext_input_payload = '0;
    endtask

    task automatic send_beats(input int n);
        int k;
        for (int i = 0; i < n; i++) begin
            ext_input_payload = {$urandom, $urandom, $urandom, $urandom};
            ext_input_valid   = 1'b1;
            exp_beat_q.push_back(ext_input_payload);
            k = 0;
            while (1) begin
                @(negedge clk);
                if (ext_input_accept) break;
                if (++k > 300) begin
                    check_eq("beat_accept_timeout", 0, 1);
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        ext_input_valid   = 1'b0;
        ext_input_payload = '0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (exp_resp_q.size() != 0) begin
            @(negedge clk);
            if (++k > 1000) begin
                check_eq("resp_timeout", exp_resp_q.size(), 0);
                exp_resp_q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst               = 1'b1;
        ext_input_valid   = 1'b0;
        ext_input_payload = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_accept", ext_input_accept, 1);
        check_eq("rst_out_valid", ext_output_valid, 0);
        check_eq("rst_out_payload", ext_output_payload, 0);
        check_eq("rst_req", master_request, 0);
        check_eq("rst_req_type", master_request_type, 0);
        check_eq("rst_req_addr", master_request_local_address, 0);
        check_eq("rst_req_len", master_request_length, 0);
        check_eq("rst_src_rdy", master_dataout_src_rdy, 0);
        check_eq("rst_dataout", master_dataout, 0);
`ifdef EGRESS_INTERFACE_PERF_CNT_EN
        check_eq("rst_stat_beats", stat_beat_count, 0);
        check_eq("rst_stat_stall", stat_stall_count, 0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;

        // 64 bytes, ack after 3 cycles
        ack_delay = 3; comp_target = 4; comp_delay = 2; comp_err = 7'd0;
        send_cmd(64'h1000, 36'd64, 8'h5A, 7'd0);
        send_beats(4);
        wait_done();

        // 17 bytes: two beats, a third valid beat must stall
        comp_target = 2; comp_delay = 8;
        send_cmd(64'h0000_0001_0000_0040, 36'd17, 8'hA1, 7'd0);
        send_beats(2);
        ext_input_payload = {4{32'hDEADBEEF}};
        ext_input_valid   = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_eq("extra_beat_accept", ext_input_accept, 0);
            check_eq("extra_beat_src_rdy", master_dataout_src_rdy, 0);
        end
        @(posedge clk);
        #1;
        ext_input_valid   = 1'b0;
        ext_input_payload = '0;
        wait_done();

        // Zero length: immediate response, no request
        send_cmd(64'h2000, 36'd0, 8'h11, 7'd0);
        @(negedge clk);
        check_eq("zl_resp_valid", ext_output_valid, 1);
        check_eq("zl_no_request", master_request, 0);
        wait_done();

        // 256 bytes with random backpressure on both sides
        rdy_random = 1; acc_random = 1;
        comp_target = 16; comp_delay = 1;
        send_cmd(64'h3000, 36'd256, 8'h77, 7'd0);
        send_beats(16);
        wait_done();
        rdy_random = 0; acc_random = 0;
        @(negedge clk);
`ifdef EGRESS_INTERFACE_PERF_CNT_EN
        check_eq("stat_beats", stat_beat_count, beats_exp);
        check_eq("stat_stall", stat_stall_count, stall_exp);
`endif
        @(posedge clk);
        #1;

        // Early complete with error 0x03 before the last beat
        comp_target = 6; comp_delay = 0; comp_err = 7'h03;
        send_cmd(64'h4000, 36'd128, 8'h33, 7'h03);
        send_beats(8);
        wait_done();
        comp_err = 7'd0;

        // Complete in the same cycle as the last beat goes straight to respond
        comp_target = 3; comp_delay = 0;
        send_cmd(64'h5000, 36'd60, 8'h44, 7'd0);
        send_beats(4);
        @(negedge clk);
        check_eq("simul_direct_resp", ext_output_valid, 1);
        wait_done();

        // Reset during streaming after 2 of 8 beats
        comp_target = 8; comp_delay = 2;
        send_cmd(64'h6000, 36'd128, 8'h66, 7'd0);
        send_beats(2);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        exp_resp_q.delete();
        exp_req_q.delete();
        exp_beat_q.delete();
        check_eq("mid_rst_in_accept", ext_input_accept, 1);
        check_eq("mid_rst_src_rdy", master_dataout_src_rdy, 0);
        check_eq("mid_rst_req", master_request, 0);
        check_eq("mid_rst_out_valid", ext_output_valid, 0);
`ifdef EGRESS_INTERFACE_PERF_CNT_EN
        check_eq("mid_rst_stat_beats", stat_beat_count, 0);
`endif
        @(posedge clk);
        #1;

        // Fresh command after reset
        comp_target = 3; comp_delay = 1;
        send_cmd(64'h7000, 36'd48, 8'h77, 7'd0);
        send_beats(3);
        wait_done();
        @(negedge clk);
`ifdef EGRESS_INTERFACE_PERF_CNT_EN
        check_eq("post_rst_stat_beats", stat_beat_count, beats_exp);
`endif
        check_eq("beat_q_drained", exp_beat_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
